sym_fetch_scheduler: RTL

//  Per-frame read sequencer for the program/symbol CommandBuffer. Once per frame, on

---
 rtl/sym_fetch_scheduler.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/sym_fetch_scheduler.sv
// ---------------------------------------------------------------------------
// sym_fetch_scheduler
//
// Per-frame read sequencer for the program/symbol CommandBuffer. When vsync
// falls while symbol mode is on, it walks every symbol ID in order. Each
// valid entry is read over the buffer read port, and the returned attribute
// word is captured into a staging bank. After the last ID the whole bank is
// committed in one cycle. Render therefore always sees a frame-stable
// snapshot and never a half-updated one.
//
// Ports
//   i_clk        pixel clock
//   n_btn_rst    asynchronous active-low reset
//   n_vsync      active-low vsync from display_signal
//   is_sym_mode  symbol mode enable from DataAggregator
//   valid_idx    per-ID valid flags from the CommandBuffer
//   prog_rdata   CommandBuffer read data (RD_LAT cycles after the read edge)
//   prog_re      CommandBuffer read enable (one cycle per valid ID)
//   prog_raddr   CommandBuffer read address; holds its value while prog_re=0
//   sym_attr     committed attributes; ID k at [k*PROG_BITS +: PROG_BITS]
//   sym_valid    committed per-ID valid flags
//   frame_ready  one-cycle pulse when a new snapshot is committed
//   fetch_busy   high while the sequencer is not idle
//   overrun      one-cycle pulse when a vsync trigger arrives while busy
// ---------------------------------------------------------------------------
module sym_fetch_scheduler #(
    parameter int PROG_BITS = 48,
    parameter int NUM_SYM   = 2,
    parameter int ADDR_W    = 2,
    parameter int RD_LAT    = 1
) (
    input  logic                         i_clk,
    input  logic                         n_btn_rst,
    input  logic                         n_vsync,
    input  logic                         is_sym_mode,
    input  logic [NUM_SYM-1:0]           valid_idx,
    input  logic [PROG_BITS-1:0]         prog_rdata,
    output logic                         prog_re,
    output logic [ADDR_W-1:0]            prog_raddr,
    output logic [NUM_SYM*PROG_BITS-1:0] sym_attr,
    output logic [NUM_SYM-1:0]           sym_valid,
    output logic                         frame_ready,
    output logic                         fetch_busy,
    output logic                         overrun
);

    localparam int IDX_W = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
    localparam int CNT_W = $clog2(RD_LAT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SYM - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [PROG_BITS-1:0]           stage_q [NUM_SYM];
    logic [PROG_BITS-1:0]           stage_d [NUM_SYM];
    logic [NUM_SYM-1:0]             stage_v_q, stage_v_d;
    logic [NUM_SYM*PROG_BITS-1:0]   sym_attr_q, sym_attr_d;
    logic [NUM_SYM-1:0]             sym_valid_q, sym_valid_d;
    logic                           frame_ready_q, frame_ready_d;
    logic                           overrun_q, overrun_d;
    logic [ADDR_W-1:0]              raddr_q, raddr_d;

    // vsync is sampled once and then compared with the previous sample. The
    // trigger is therefore seen one edge after n_vsync is first sampled low.
    // This is the leading "+1" in the fetch latency.
    logic vsync_s_q, vsync_prev_q;
    logic trigger;
    logic advance;

    assign trigger = is_sym_mode & ~vsync_s_q & vsync_prev_q;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred. Combinational logic uses
    // blocking '=', and the state registers below use non-blocking '<='.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        stage_d       = stage_q;
        stage_v_d     = stage_v_q;
        sym_attr_d    = sym_attr_q;
        sym_valid_d   = sym_valid_q;
        frame_ready_d = 1'b0;
        overrun_d     = 1'b0;
        raddr_d       = raddr_q;
        prog_re       = 1'b0;
        prog_raddr    = raddr_q;
        advance       = 1'b0;

        if (!is_sym_mode) begin
            // Mode drop aborts any fetch. The old attributes stay in place,
            // but none of them are marked valid.
            state_d     = S_IDLE;
            sym_valid_d = '0;
        end else begin
            if (trigger && state_q != S_IDLE) begin
                overrun_d = 1'b1;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        state_d   = S_ISSUE;
                        idx_d     = '0;
                        stage_v_d = '0;
                    end
                end
                S_ISSUE: begin
                    if (valid_idx[idx_q]) begin
                        prog_re    = 1'b1;
                        prog_raddr = ADDR_W'(idx_q);
                        raddr_d    = ADDR_W'(idx_q);
                        cnt_d      = CNT_W'(RD_LAT);
                        state_d    = S_WAIT;
                    end else begin
                        stage_v_d[idx_q] = 1'b0;
                        advance          = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        stage_d[idx_q]   = prog_rdata;
                        stage_v_d[idx_q] = 1'b1;
                        advance          = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_COMMIT: begin
                    for (int k = 0; k < NUM_SYM; k++) begin
                        sym_attr_d[k*PROG_BITS +: PROG_BITS] = stage_q[k];
                    end
                    sym_valid_d   = stage_v_q;
                    frame_ready_d = 1'b1;
                    state_d       = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase

            // The walk stops at the last ID and never wraps back to 0.
            if (advance) begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_COMMIT;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_ISSUE;
                end
            end
        end
    end

    // NOTE: the staging bank is reset along with the control state. It is
    // only NUM_SYM words, and a reset must leave it holding a defined zero
    // snapshot.
    always_ff @(posedge i_clk or negedge n_btn_rst) begin
        if (!n_btn_rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            for (int k = 0; k < NUM_SYM; k++) begin
                stage_q[k] <= '0;
            end
            stage_v_q     <= '0;
            sym_attr_q    <= '0;
            sym_valid_q   <= '0;
            frame_ready_q <= 1'b0;
            overrun_q     <= 1'b0;
            raddr_q       <= '0;
            vsync_s_q     <= 1'b1;
            vsync_prev_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            stage_q       <= stage_d;
            stage_v_q     <= stage_v_d;
            sym_attr_q    <= sym_attr_d;
            sym_valid_q   <= sym_valid_d;
            frame_ready_q <= frame_ready_d;
            overrun_q     <= overrun_d;
            raddr_q       <= raddr_d;
            vsync_s_q     <= n_vsync;
            vsync_prev_q  <= vsync_s_q;
        end
    end

    assign sym_attr    = sym_attr_q;
    assign sym_valid   = sym_valid_q;
    assign frame_ready = frame_ready_q;
    assign overrun     = overrun_q;
    assign fetch_busy  = (state_q != S_IDLE);

endmodule
